// File: rtl/uart_dev_pkg.sv
// Shared definitions for the memory-mapped UART device.
// Register offsets relative to BASE_ADDR, CON bit positions, and the TX/RX
// state encodings.
package uart_dev_pkg;

  localparam logic [31:0] TXD_OFF = 32'h0;
  localparam logic [31:0] RXD_OFF = 32'h4;
  localparam logic [31:0] CON_OFF = 32'h8;

  localparam int CON_TX_BUSY  = 0;
  localparam int CON_RX_VALID = 1;
  localparam int CON_TX_DONE  = 2;
  localparam int CON_RX_OVR   = 3;
  localparam int CON_RX_EN    = 4;
  localparam int CON_TX_IE    = 5;
  localparam int CON_RX_IE    = 6;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// UART receive engine: two-flop synchroniser, start/data/stop FSM.
// Ports:
//   clk, reset   system clock, async active-high reset
//   rx_en        receiver enable; low forces IDLE on the next edge
//   uart_rx      raw asynchronous serial input
//   byte_done    one-cycle pulse, the cycle before the edge that ends a good frame
//   byte_data    received byte, valid while byte_done is high
//   frame_err    one-cycle pulse when the stop bit samples low
module uart_rx_core
  import uart_dev_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic       uart_rx,
  output logic       byte_done,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

  // sync[1] is the synchronised line, sync[2] its previous value for edge detect
  logic [2:0]    sync;
  logic          rx_s, rx_prev;
  rx_state_e     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;

  assign rx_s      = sync[1];
  assign rx_prev   = sync[2];
  assign byte_data = sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= 3'b111;
      state <= RX_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      sync  <= {sync[1:0], uart_rx};
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    idx_n     = idx;
    sh_n      = sh;
    byte_done = 1'b0;
    frame_err = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (rx_prev && !rx_s) state_n = RX_START;
      end
      RX_START: if (cnt == CNT_HALF) begin
        // line back high at mid-start is treated as a glitch
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt == CNT_LAST) begin
        cnt_n = '0;
        sh_n  = {rx_s, sh[7:1]};
        idx_n = idx + 3'd1;
        if (idx == 3'd7) state_n = RX_STOP;
      end
      RX_STOP: if (cnt == CNT_LAST) begin
        cnt_n     = '0;
        state_n   = RX_IDLE;
        byte_done = rx_s;
        frame_err = !rx_s;
      end
      default: state_n = RX_IDLE;
    endcase
    if (!rx_en) begin
      state_n   = RX_IDLE;
      cnt_n     = '0;
      byte_done = 1'b0;
      frame_err = 1'b0;
    end
  end

endmodule

// File: rtl/bus_uart_device.sv
// Memory-mapped UART responder on the CPU peripheral bus.
// Registers: TXD @BASE_ADDR, RXD @BASE_ADDR+4, CON @BASE_ADDR+8.
// Reads are combinational (same cycle), writes commit on the next edge.
// Optional macro UART_IRQ_EN adds a registered irq output.
// Ports:
//   clk, reset            system clock, async active-high reset
//   dev_read, dev_write   one-cycle bus strobes
//   bus_addr, bus_wdata   bus address / write data
//   bus_rdata             read data, 0 when dev_read is low
//   uart_rx, uart_tx      serial lines (tx idles high)
//   irq                   (UART_IRQ_EN only) interrupt request
module bus_uart_device
  import uart_dev_pkg::*;
#(
  parameter int          CLK_HZ    = 100000000,
  parameter int          BAUD      = 9600,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dev_read,
  input  logic        dev_write,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic        uart_rx,
  output logic        uart_tx
`ifdef UART_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  if (DIV < 4) begin : g_div_err
    $error("bus_uart_device: CLK_HZ/BAUD must be at least 4");
  end

  logic       sel_txd, sel_rxd, sel_con, wr_con, rd_rxd;
  logic [7:0] txd, rxd;
  logic       tx_done, rx_ovr, rx_valid, rx_en, tx_ie, rx_ie;
  logic       tx_busy, tx_start, tx_fin;
  logic       rx_byte_done, rx_frame_err;
  logic [7:0] rx_byte;
  logic [31:0] con_rd;

  assign sel_txd = bus_addr == BASE_ADDR + TXD_OFF;
  assign sel_rxd = bus_addr == BASE_ADDR + RXD_OFF;
  assign sel_con = bus_addr == BASE_ADDR + CON_OFF;
  assign wr_con  = dev_write && sel_con;
  assign rd_rxd  = dev_read && sel_rxd;

  // ---------------- TX FSM ----------------
  tx_state_e     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_idx, tx_idx_n;

  assign tx_busy  = tx_state != TX_IDLE;
  assign tx_start = dev_write && sel_txd && !tx_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_idx_n   = tx_idx;
    tx_fin     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        tx_idx_n = '0;
        if (tx_start) tx_state_n = TX_START;
      end
      TX_START: if (tx_cnt == CNT_LAST) begin
        tx_cnt_n   = '0;
        tx_state_n = TX_DATA;
      end
      TX_DATA: if (tx_cnt == CNT_LAST) begin
        tx_cnt_n = '0;
        tx_idx_n = tx_idx + 3'd1;
        if (tx_idx == 3'd7) tx_state_n = TX_STOP;
      end
      TX_STOP: if (tx_cnt == CNT_LAST) begin
        tx_cnt_n   = '0;
        tx_state_n = TX_IDLE;
        tx_fin     = 1'b1;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // TXD is frozen while busy, so the frame is shifted straight out of it.
  // Decoded from state flops only, so reset forces the line high at once.
  assign uart_tx = (tx_state == TX_START) ? 1'b0 :
                   (tx_state == TX_DATA)  ? txd[tx_idx] : 1'b1;

  // ---------------- RX ----------------
  uart_rx_core #(.DIV(DIV)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx_en     (rx_en),
    .uart_rx   (uart_rx),
    .byte_done (rx_byte_done),
    .byte_data (rx_byte),
    .frame_err (rx_frame_err)
  );

  // ---------------- register file ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txd      <= '0;
      rxd      <= '0;
      tx_done  <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_valid <= 1'b0;
      rx_en    <= 1'b0;
      tx_ie    <= 1'b0;
      rx_ie    <= 1'b0;
    end else begin
      if (tx_start) txd <= bus_wdata[7:0];
      if (wr_con) begin
        rx_en <= bus_wdata[CON_RX_EN];
        tx_ie <= bus_wdata[CON_TX_IE];
        rx_ie <= bus_wdata[CON_RX_IE];
        if (bus_wdata[CON_TX_DONE]) tx_done <= 1'b0;
        if (bus_wdata[CON_RX_OVR])  rx_ovr  <= 1'b0;
      end
      // hardware sets come after the W1C clears so they win on a collision
      if (tx_fin) tx_done <= 1'b1;
      if (rd_rxd) rx_valid <= 1'b0;
      if (rx_byte_done) begin
        if (!rx_valid || rd_rxd) begin
          rxd      <= rx_byte;
          rx_valid <= 1'b1;
        end else begin
          rx_ovr <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    con_rd               = '0;
    con_rd[CON_TX_BUSY]  = tx_busy;
    con_rd[CON_RX_VALID] = rx_valid;
    con_rd[CON_TX_DONE]  = tx_done;
    con_rd[CON_RX_OVR]   = rx_ovr;
    con_rd[CON_RX_EN]    = rx_en;
    con_rd[CON_TX_IE]    = tx_ie;
    con_rd[CON_RX_IE]    = rx_ie;
  end

  always_comb begin
    bus_rdata = '0;
    if (dev_read) begin
      if (sel_txd)      bus_rdata = {24'b0, txd};
      else if (sel_rxd) bus_rdata = {24'b0, rxd};
      else if (sel_con) bus_rdata = con_rd;
    end
  end

`ifdef UART_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= (tx_done & tx_ie) | (rx_valid & rx_ie);
  end
`endif

  // framing errors just drop the byte; nothing architectural records them
  logic unused_ok;
  assign unused_ok = ^{bus_wdata[31:8], rx_frame_err};

endmodule
